// File: rtl/muldiv_pkg.sv
// muldiv_pkg: RV32M funct3 encodings, FSM states and operand-class helpers for muldiv_unit
package muldiv_pkg;
  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;
  typedef enum logic [1:0] {IDLE = 2'b00, CALC = 2'b01, FIX = 2'b10, DONE = 2'b11} state_t;
  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction
  function automatic logic a_signed(input logic [2:0] op);
    return op == OP_MUL || op == OP_MULH || op == OP_MULHSU || op == OP_DIV || op == OP_REM;
  endfunction
  function automatic logic b_signed(input logic [2:0] op);
    return op == OP_MULH || op == OP_DIV || op == OP_REM;
  endfunction
endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, one bit per clock on a shared
// shift register and adder/subtractor, with start/busy/result_valid handshake.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] dataA,
  input  logic [XLEN-1:0] dataB,
  input  logic            kill,
  output logic            busy,
  output logic            result_valid,
  output logic [XLEN-1:0] result,
  output logic            div_by_zero
);
  localparam int CNT_W = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  state_t r_state, w_next;
  logic [2:0]      r_op;
  logic            r_sa, r_sb, r_dbz;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0] r_acc, r_sh, r_mag;
  logic            w_accept, w_dbz, w_ovf, w_sa, w_sb, w_div, w_q;
  logic [XLEN-1:0] w_mag_a, w_mag_b, w_acc_n, w_sh_n, w_quo, w_rem, w_res;
  logic [XLEN:0]   w_shift;
  logic [XLEN+1:0] w_lhs, w_rhs, w_sum;
  logic [2*XLEN-1:0] w_prod, w_prod_f;
  assign w_accept = start && (r_state == IDLE || r_state == DONE);
  assign w_dbz    = is_div(op) && dataB == '0;
  assign w_ovf    = is_div(op) && b_signed(op) && dataA == MIN_NEG && &dataB;
  assign w_sa     = a_signed(op) && dataA[XLEN-1];
  assign w_sb     = b_signed(op) && dataB[XLEN-1];
  assign w_mag_a  = w_sa ? -dataA : dataA;
  assign w_mag_b  = w_sb ? -dataB : dataB;
  always_comb begin
    w_next       = r_state;
    busy         = r_state == CALC || r_state == FIX;
    result_valid = r_state == DONE;
    if (w_accept) w_next = (w_dbz || w_ovf) ? FIX : CALC;
    else if (kill && busy) w_next = IDLE;
    else if (r_state == CALC && r_cnt == CNT_W'(1)) w_next = FIX;
    else if (r_state == FIX) w_next = DONE;
    else if (r_state == DONE) w_next = IDLE;
  end
  // Multiply adds r_mag when the multiplier LSB is set; divide subtracts r_mag via ~x+1.
  assign w_div   = is_div(r_op);
  assign w_shift = {r_acc, r_sh[XLEN-1]};
  assign w_lhs   = w_div ? {1'b0, w_shift} : {2'b00, r_acc};
  assign w_rhs   = w_div ? ~{2'b00, r_mag} : (r_sh[0] ? {2'b00, r_mag} : '0);
  assign w_sum   = w_lhs + w_rhs + (XLEN+2)'(w_div);
  assign w_q     = ~w_sum[XLEN+1];
  assign w_acc_n = w_div ? (w_q ? w_sum[XLEN-1:0] : w_shift[XLEN-1:0]) : w_sum[XLEN:1];
  assign w_sh_n  = w_div ? {r_sh[XLEN-2:0], w_q} : {w_sum[0], r_sh[XLEN-1:1]};
  assign w_prod   = {r_acc, r_sh};
  assign w_prod_f = (r_sa ^ r_sb) ? -w_prod : w_prod;
  assign w_quo    = (r_sa ^ r_sb) ? -r_sh : r_sh;
  assign w_rem    = r_sa ? -r_acc : r_acc;
  assign w_res    = w_div ? (r_op[1] ? w_rem : w_quo)
                          : (r_op == OP_MUL ? w_prod_f[XLEN-1:0] : w_prod_f[2*XLEN-1:XLEN]);
  // Special cases preload quotient/remainder with cleared signs so FIX passes them through.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_op        <= OP_MUL;
      r_sa        <= 1'b0;
      r_sb        <= 1'b0;
      r_dbz       <= 1'b0;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_sh        <= '0;
      r_mag       <= '0;
      result      <= '0;
      div_by_zero <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op  <= op;
        r_sa  <= w_sa && !w_dbz && !w_ovf;
        r_sb  <= w_sb && !w_dbz && !w_ovf;
        r_dbz <= w_dbz;
        r_cnt <= CNT_W'(XLEN);
        r_acc <= w_dbz ? dataA : '0;
        r_sh  <= w_dbz ? '1 : w_ovf ? MIN_NEG : is_div(op) ? w_mag_a : w_mag_b;
        r_mag <= is_div(op) ? w_mag_b : w_mag_a;
      end else if (r_state == CALC) begin
        r_cnt <= r_cnt - CNT_W'(1);
        r_acc <= w_acc_n;
        r_sh  <= w_sh_n;
      end
      if (r_state == FIX && !kill) begin
        result      <= w_res;
        div_by_zero <= r_dbz;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: table-driven directed vectors plus hand-written handshake,
// kill, reset and back-to-back sequences for muldiv_unit at XLEN=32.
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] dataA = '0;
  logic [31:0] dataB = '0;
  logic        kill = 1'b0;
  logic        busy, result_valid, div_by_zero;
  logic [31:0] result;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        dbz;
    int          lat;
  } vec_t;
  vec_t v[12];
  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .dataA(dataA), .dataB(dataB),
    .kill(kill), .busy(busy), .result_valid(result_valid), .result(result),
    .div_by_zero(div_by_zero)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask
  task automatic launch(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; dataA = a; dataB = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_valid(output int n);
    n = 1;
    while (!result_valid && n < 100) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
  endtask
  int n;
  logic seen;
  initial begin
    v[0]  = '{3'b000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 34};
    v[1]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 34};
    v[2]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 34};
    v[3]  = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 34};
    v[4]  = '{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 34};
    v[5]  = '{3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0, 34};
    v[6]  = '{3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0, 34};
    v[7]  = '{3'b101, 32'd100,      32'd7,        32'h0000000E, 1'b0, 34};
    v[8]  = '{3'b111, 32'd100,      32'd7,        32'h00000002, 1'b0, 34};
    v[9]  = '{3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b1, 2};
    v[10] = '{3'b111, 32'd5,        32'd0,        32'h00000005, 1'b1, 2};
    v[11] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 2};
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 32'(busy), 0);
    check("reset_valid", 32'(result_valid), 0);
    check("reset_result", result, 0);
    check("reset_dbz", 32'(div_by_zero), 0);
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      launch(v[i].op, v[i].a, v[i].b);
      check($sformatf("v%0d_busy", i), 32'(busy), 1);
      wait_valid(n);
      check($sformatf("v%0d_latency", i), n, v[i].lat);
      check($sformatf("v%0d_result", i), result, v[i].res);
      check($sformatf("v%0d_dbz", i), 32'(div_by_zero), 32'(v[i].dbz));
      @(negedge clk);
      check($sformatf("v%0d_pulse", i), 32'(result_valid), 0);
    end
    launch(3'b110, 32'h80000000, 32'hFFFFFFFF);
    wait_valid(n);
    check("rem_ovf_latency", n, 2);
    check("rem_ovf_result", result, 0);
    launch(3'b101, 32'd100, 32'd7);
    for (int k = 1; k < 4; k++) @(negedge clk);
    start = 1'b1; op = 3'b000; dataA = 32'd3; dataB = 32'd4;
    @(negedge clk);
    start = 1'b0;
    wait_valid(n);
    check("ignore_latency", n + 4, 34);
    check("ignore_result", result, 32'h0000000E);
    launch(3'b000, 32'd3, 32'd4);
    for (int k = 1; k < 10; k++) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill_busy", 32'(busy), 0);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      seen = seen | result_valid;
    end
    check("kill_no_valid", 32'(seen), 0);
    check("kill_result_kept", result, 32'h0000000E);
    launch(3'b111, 32'd5, 32'd0);
    wait_valid(n);
    check("pre_reset_dbz", 32'(div_by_zero), 1);
    launch(3'b100, 32'd50, 32'd3);
    for (int k = 1; k < 8; k++) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_valid", 32'(result_valid), 0);
    check("midrst_result", result, 0);
    check("midrst_dbz", 32'(div_by_zero), 0);
    launch(3'b000, 32'd7, 32'd3);
    wait_valid(n);
    check("b2b_first", result, 32'd21);
    start = 1'b1; op = 3'b011; dataA = 32'h00010000; dataB = 32'h00010000;
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", 32'(busy), 1);
    check("b2b_no_double_valid", 32'(result_valid), 0);
    wait_valid(n);
    check("b2b_latency", n, 34);
    check("b2b_result", result, 32'h00000001);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
